mem_arbiter: RTL

- Shares the single-port synchronous RAM between two bus masters: m0 (CPU instruction fetch and LD/ST) and m1 (program loader / debug port).
- Round-robin arbitration, one access per cycle.
- Optional lock lets a master hold the bus for a multi-beat sequence, e.g. the CPU's 4-byte instruction fetch.
- Sits between the masters and the RAM; RAM read data is valid the cycle after the address is presented.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle tying the two masters and the single-port RAM to the arbiter.
// The arbiter takes the slave view; the masters/RAM side takes the master view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              m0_req;
  logic              m0_lock;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;

  logic              m1_req;
  logic              m1_lock;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;

  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
    output rdata, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
    input  rdata, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two masters, with an
// optional bus lock bounded by MAX_HOLD beats while the other master waits.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic              rd_pend0_q, rd_pend0_d;
  logic              rd_pend1_q, rd_pend1_d;

  logic              gnt0;
  logic              gnt1;
  logic              hold_expired;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              we_mux;

  assign hold_expired = (hold_cnt_q == HOLD_MAX);

  // Lock owner keeps the bus unless it has used up its beats and the other side waits.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (state_q == OWN0 && bus.m0_req && !(bus.m1_req && hold_expired)) begin
        gnt0 = 1'b1;
      end else if (state_q == OWN1 && bus.m1_req && !(bus.m0_req && hold_expired)) begin
        gnt1 = 1'b1;
      end else if (bus.m0_req && bus.m1_req) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = bus.m0_req;
        gnt1 = bus.m1_req;
      end
    end
  end

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    we_mux    = 1'b0;
    if (gnt0) begin
      addr_mux  = bus.m0_addr;
      wdata_mux = bus.m0_wdata;
      we_mux    = bus.m0_we;
    end else if (gnt1) begin
      addr_mux  = bus.m1_addr;
      wdata_mux = bus.m1_wdata;
      we_mux    = bus.m1_we;
    end
  end

  always_comb begin
    state_d    = IDLE;
    hold_cnt_d = '0;
    last_d     = last_q;
    rd_pend0_d = gnt0 && !bus.m0_we;
    rd_pend1_d = gnt1 && !bus.m1_we;
    if (gnt0) begin
      last_d = 1'b0;
      if (bus.m0_lock) begin
        state_d    = OWN0;
        hold_cnt_d = (state_q != OWN0) ? 4'd1 :
                     (hold_expired ? HOLD_MAX : hold_cnt_q + 4'd1);
      end
    end else if (gnt1) begin
      last_d = 1'b1;
      if (bus.m1_lock) begin
        state_d    = OWN1;
        hold_cnt_d = (state_q != OWN1) ? 4'd1 :
                     (hold_expired ? HOLD_MAX : hold_cnt_q + 4'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      hold_cnt_q <= '0;
      rd_pend0_q <= 1'b0;
      rd_pend1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      rd_pend0_q <= rd_pend0_d;
      rd_pend1_q <= rd_pend1_d;
    end
  end

  // A read issued just before reset must not surface while reset is held.
  assign bus.m0_rvalid = rd_pend0_q && !rst;
  assign bus.m1_rvalid = rd_pend1_q && !rst;
  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.mem_we    = we_mux;
endmodule
